// File: rtl/uxa_ps2_rxfifo_pkg.sv
// Shared constants for the UXA PS/2 receive path: status-word bit map and default depth.
package uxa_ps2_pkg;

  // Bit positions inside the 16-bit status word presented on the read bus.
  localparam int unsigned QB_DATA_LSB = 0;
  localparam int unsigned QB_D        = 8;
  localparam int unsigned QB_C        = 9;
  localparam int unsigned QB_OVF      = 14;
  localparam int unsigned QB_VALID    = 15;

  // Default log2 of FIFO depth (16 entries).
  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

endpackage

// File: rtl/uxa_ps2_rxfifo_if.sv
// Push/pop/status bundle between the PS/2 frame receiver, bus control and the RX FIFO.
interface uxa_ps2_rxfifo_if;

  logic        we_i;
  logic [7:0]  dat_i;
  logic        rp_inc_i;
  logic [15:0] q_o;
  logic        full_o;
  logic        empty_o;

  // Producer / bus-control side.
  modport master (
    output we_i,
    output dat_i,
    output rp_inc_i,
    input  q_o,
    input  full_o,
    input  empty_o
  );

  // FIFO side.
  modport slave (
    input  we_i,
    input  dat_i,
    input  rp_inc_i,
    output q_o,
    output full_o,
    output empty_o
  );

endinterface

// File: rtl/uxa_sync2.sv
// Two-flop synchronizer for a single asynchronous line, with selectable reset level.
module uxa_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the raw line through two flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uxa_ps2_rxfifo.sv
// PS/2 receive FIFO with sticky overflow, edge-detected pop and status-word formatting.
module uxa_ps2_rxfifo
  import uxa_ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic           sys_clk_i,
  input  logic           sys_reset_ni,
  input  logic           ps2_c_i,
  input  logic           ps2_d_i,
  uxa_ps2_rxfifo_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCnt = (DEPTH_LOG2 + 1)'(Depth);

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  rp_inc_q;
  logic                  full, empty;
  logic                  pop_evt, do_pop, do_push;
  logic                  c_sync, d_sync;

  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);

  // Pointer, count and overflow next-state; a pop edge frees a slot for a same-cycle push.
  always_comb begin
    pop_evt = bus.rp_inc_i & ~rp_inc_q;
    do_pop  = pop_evt & ~empty;
    do_push = bus.we_i & (~full | do_pop);
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (do_push) wp_d = wp_q + DEPTH_LOG2'(1);
    if (do_pop)  rp_d = rp_q + DEPTH_LOG2'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   cnt_d = cnt_q - (DEPTH_LOG2 + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop_evt) begin
      ovf_d = 1'b0;
    end else if (bus.we_i && full) begin
      ovf_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge sys_clk_i or negedge sys_reset_ni) begin
    if (!sys_reset_ni) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rp_inc_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rp_inc_q <= bus.rp_inc_i;
    end
  end

  // Storage array; contents are don't-care until written, validity comes from the count.
  always_ff @(posedge sys_clk_i) begin
    if (do_push) mem_q[wp_q] <= bus.dat_i;
  end

  uxa_sync2 #(
    .ResetVal (1'b1)
  ) u_sync_c (
    .clk_i  (sys_clk_i),
    .rst_ni (sys_reset_ni),
    .d_i    (ps2_c_i),
    .q_o    (c_sync)
  );

  uxa_sync2 #(
    .ResetVal (1'b1)
  ) u_sync_d (
    .clk_i  (sys_clk_i),
    .rst_ni (sys_reset_ni),
    .d_i    (ps2_d_i),
    .q_o    (d_sync)
  );

  // Assemble the status word from registered state only.
  always_comb begin
    bus.q_o = '0;
    bus.q_o[QB_DATA_LSB +: 8] = empty ? 8'h00 : mem_q[rp_q];
    bus.q_o[QB_D]     = d_sync;
    bus.q_o[QB_C]     = c_sync;
    bus.q_o[QB_OVF]   = ovf_q;
    bus.q_o[QB_VALID] = ~empty;
  end

  assign bus.full_o  = full;
  assign bus.empty_o = empty;

endmodule

// File: tb/tb_uxa_ps2_rxfifo.sv
// Self-checking bench for uxa_ps2_rxfifo: vector table plus scoreboard-driven corner cases.
module tb_uxa_ps2_rxfifo;
  import uxa_ps2_pkg::*;

  logic clk;
  logic rst_n;
  logic ps2_c, ps2_d;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_q [$];
  logic       exp_ovf;

  uxa_ps2_rxfifo_if bus ();

  uxa_ps2_rxfifo #(
    .DEPTH_LOG2 (4)
  ) dut (
    .sys_clk_i    (clk),
    .sys_reset_ni (rst_n),
    .ps2_c_i      (ps2_c),
    .ps2_d_i      (ps2_d),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  dat;
    logic        rp;
    logic [15:0] exp_q;
    logic        exp_empty;
    logic        exp_full;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one clock; inputs changed and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push with scoreboard update.
  task automatic push(input logic [7:0] b);
    bus.we_i  = 1'b1;
    bus.dat_i = b;
    if (exp_q.size() < 16) exp_q.push_back(b);
    else exp_ovf = 1'b1;
    tick();
    bus.we_i = 1'b0;
  endtask

  // Check head against scoreboard, then pop with one low cycle afterwards.
  task automatic pop_check(input string name);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, {15'd0, bus.empty_o}, 16'd1);
    end else begin
      check({name, "_head"}, {8'h00, bus.q_o[7:0]}, {8'h00, exp_q[0]});
      void'(exp_q.pop_front());
    end
    exp_ovf = 1'b0;
    bus.rp_inc_i = 1'b1;
    tick();
    bus.rp_inc_i = 1'b0;
    tick();
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    exp_ovf      = 1'b0;
    bus.we_i     = 1'b0;
    bus.dat_i    = 8'h00;
    bus.rp_inc_i = 1'b0;
    ps2_c        = 1'b1;
    ps2_d        = 1'b1;
    rst_n        = 1'b0;

    //               we    dat    rp    exp_q      empty full
    vecs[0]  = '{1'b1, 8'h1C, 1'b0, 16'h831C, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hF0, 1'b0, 16'h831C, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h1C, 1'b0, 16'h831C, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 16'h83F0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 16'h83F0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 16'h831C, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 16'h831C, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 16'h0300, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h5A, 1'b0, 16'h835A, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h29, 1'b0, 16'h835A, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 16'h8329, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 16'h8329, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 16'h8329, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 16'h8329, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 16'h0300, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 16'h0300, 1'b1, 1'b0};

    #12;
    check("reset_q", bus.q_o, 16'h0300);
    check("reset_empty", {15'd0, bus.empty_o}, 16'd1);
    check("reset_full", {15'd0, bus.full_o}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Line synchronizer latency.
    ps2_c = 1'b0;
    tick();
    check("c_low_1edge", bus.q_o, 16'h0300);
    tick();
    check("c_low_2edge", bus.q_o, 16'h0100);
    ps2_c = 1'b1;
    ps2_d = 1'b0;
    tick();
    tick();
    tick();
    check("d_low", bus.q_o, 16'h0200);
    ps2_d = 1'b1;
    tick();
    tick();
    tick();
    check("lines_idle", bus.q_o, 16'h0300);

    // Table-driven pushes, single pops and a held pop level.
    for (int i = 0; i < 16; i++) begin
      bus.we_i     = vecs[i].we;
      bus.dat_i    = vecs[i].dat;
      bus.rp_inc_i = vecs[i].rp;
      tick();
      check($sformatf("vec%0d_q", i), bus.q_o, vecs[i].exp_q);
      check($sformatf("vec%0d_flags", i), {14'd0, bus.empty_o, bus.full_o},
            {14'd0, vecs[i].exp_empty, vecs[i].exp_full});
    end
    bus.we_i     = 1'b0;
    bus.rp_inc_i = 1'b0;

    // Overflow: 17 pushes into 16 entries.
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i <= 16; i++) push(8'(i));
    check("ovf_full", {15'd0, bus.full_o}, 16'd1);
    check("ovf_flag", {15'd0, bus.q_o[QB_OVF]}, {15'd0, exp_ovf});
    for (int i = 0; i < 16; i++) begin
      pop_check($sformatf("ovf_pop%0d", i));
      if (i == 0) check("ovf_cleared", {15'd0, bus.q_o[QB_OVF]}, {15'd0, exp_ovf});
    end
    check("ovf_drained", bus.q_o, 16'h0300);

    // Full FIFO with push and pop edge in the same cycle.
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    bus.we_i     = 1'b1;
    bus.dat_i    = 8'hAA;
    bus.rp_inc_i = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(8'hAA);
    exp_ovf = 1'b0;
    tick();
    bus.we_i     = 1'b0;
    bus.rp_inc_i = 1'b0;
    check("sim_full", {15'd0, bus.full_o}, 16'd1);
    check("sim_ovf", {15'd0, bus.q_o[QB_OVF]}, {15'd0, exp_ovf});
    tick();
    for (int i = 0; i < 16; i++) pop_check($sformatf("sim_pop%0d", i));
    check("sim_drained", {15'd0, bus.empty_o}, 16'd1);

    // Asynchronous reset mid-stream with a pop edge pending.
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    bus.rp_inc_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_mid_q", bus.q_o, 16'h0300);
    check("rst_mid_empty", {15'd0, bus.empty_o}, 16'd1);
    bus.rp_inc_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h12);
    check("post_rst_q", bus.q_o, 16'h8312);
    pop_check("post_rst_pop");
    check("post_rst_empty", bus.q_o, 16'h0300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
